// File: rtl/spad_types_pkg.sv
// Shared types, parameter defaults and the arbitration priority function
// for the scratchpad SRAM arbiter.
package spad_types_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SA   = 2'd1,
    VC   = 2'd2,
    BE   = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } resp_t;

  localparam int SRAM_LAT_DEF   = 2;
  localparam int STARVE_MAX_DEF = 8;
  localparam int BURST_MAX_DEF  = 32;

  // Promotion lifts SA above BE; otherwise fixed BE > VC > SA.
  function automatic owner_t pick_owner(input logic promote, input logic be_ok,
                                        input logic vc_ok, input logic sa_ok);
    owner_t win;
    win = NONE;
    if (promote && sa_ok)  win = SA;
    else if (be_ok)        win = BE;
    else if (vc_ok)        win = VC;
    else if (sa_ok)        win = SA;
    return win;
  endfunction

endpackage

// File: rtl/spad_sram_arbiter_if.sv
// Requester/arbiter bundle: request lines in, ownership and read-return out.
interface spad_sram_arbiter_if;
  import spad_types_pkg::*;

  logic       sram_req_be;
  logic       sram_req_vc;
  logic       sram_req_sa;
  logic       be_lock;
  logic       vc_write;
  logic       sa_write;
  logic       sram_reserved_be;
  logic       sram_reserved_vc;
  logic       sram_reserved_sa;
  owner_t     xbar_owner;
  logic [1:0] resp_valid;
  owner_t     resp_owner;
  logic       starve_promote;

  modport master (
    output sram_req_be, sram_req_vc, sram_req_sa, be_lock, vc_write, sa_write,
    input  sram_reserved_be, sram_reserved_vc, sram_reserved_sa,
    input  xbar_owner, resp_valid, resp_owner, starve_promote
  );

  modport slave (
    input  sram_req_be, sram_req_vc, sram_req_sa, be_lock, vc_write, sa_write,
    output sram_reserved_be, sram_reserved_vc, sram_reserved_sa,
    output xbar_owner, resp_valid, resp_owner, starve_promote
  );

endinterface

// File: rtl/spad_resp_pipe.sv
// Fixed-latency shift pipeline tracking which granted beat returns read data
// SRAM_LAT cycles after its grant cycle.
module spad_resp_pipe
  import spad_types_pkg::*;
#(
  parameter int SRAM_LAT = SRAM_LAT_DEF
) (
  input  logic  CLK,
  input  logic  nRST,
  input  resp_t push,
  output resp_t tail
);

  resp_t stage_reg [SRAM_LAT];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SRAM_LAT; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= push;
      for (int i = 1; i < SRAM_LAT; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign tail = stage_reg[SRAM_LAT-1];

endmodule

// File: rtl/spad_sram_arbiter.sv
// Three-way scratchpad SRAM arbiter (BE/VC/SA) with registered grants,
// BE burst lock, SA starvation promotion and read-return tracking.
module spad_sram_arbiter
  import spad_types_pkg::*;
#(
  parameter int SRAM_LAT   = SRAM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input logic                CLK,
  input logic                nRST,
  spad_sram_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  // The GRANT beat that opens a burst is not counted, so the final BURST
  // beat sees BURST_MAX-2 and the lock yields BURST_MAX beats in total.
  localparam logic [5:0] BURST_LAST = 6'(BURST_MAX - 2);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg, owner_next, arb_owner;
  logic              write_reg, write_next;
  logic [5:0]        beat_cnt_reg, beat_cnt_next;
  logic [WAIT_W-1:0] sa_wait_reg;
  logic              promote, be_ok, vc_ok, sa_ok;
  logic              burst_cont, burst_start;
  resp_t             push, tail;

  // A requester owning the current beat is masked from the next arbitration.
  assign be_ok     = bus.sram_req_be && (owner_reg != BE);
  assign vc_ok     = bus.sram_req_vc && (owner_reg != VC);
  assign sa_ok     = bus.sram_req_sa && (owner_reg != SA);
  assign promote   = (sa_wait_reg == WAIT_W'(STARVE_MAX));
  assign arb_owner = pick_owner(promote, be_ok, vc_ok, sa_ok);

  assign burst_cont  = bus.sram_req_be && bus.be_lock && (beat_cnt_reg < BURST_LAST);
  assign burst_start = (state_reg == GRANT) && (owner_reg == BE) && bus.sram_req_be &&
                       bus.be_lock && !(promote && sa_ok);

  always_comb begin
    state_next    = (arb_owner == NONE) ? IDLE : GRANT;
    owner_next    = arb_owner;
    beat_cnt_next = beat_cnt_reg;
    write_next    = 1'b0;
    case (state_reg)
      BURST: begin
        if (burst_cont) begin
          state_next    = BURST;
          owner_next    = BE;
          beat_cnt_next = (beat_cnt_reg == 6'h3f) ? beat_cnt_reg : beat_cnt_reg + 6'd1;
        end
      end
      GRANT: begin
        if (burst_start) begin
          state_next    = BURST;
          owner_next    = BE;
          beat_cnt_next = '0;
        end
      end
      default: ;
    endcase
    if (owner_next == VC)      write_next = bus.vc_write;
    else if (owner_next == SA) write_next = bus.sa_write;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      owner_reg    <= NONE;
      write_reg    <= 1'b0;
      beat_cnt_reg <= '0;
      sa_wait_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      write_reg    <= write_next;
      beat_cnt_reg <= beat_cnt_next;
      if (!bus.sram_req_sa || (owner_reg == SA)) sa_wait_reg <= '0;
      else if (!promote)                         sa_wait_reg <= sa_wait_reg + WAIT_W'(1);
    end
  end

  // Only VC/SA reads return data; BE beats and writes shift a bubble.
  always_comb begin
    push.valid = ((owner_reg == VC) || (owner_reg == SA)) && !write_reg;
    push.owner = push.valid ? owner_reg : NONE;
  end

  spad_resp_pipe #(
    .SRAM_LAT (SRAM_LAT)
  ) u_resp_pipe (
    .CLK  (CLK),
    .nRST (nRST),
    .push (push),
    .tail (tail)
  );

  assign bus.sram_reserved_be = (owner_reg == BE);
  assign bus.sram_reserved_vc = (owner_reg == VC);
  assign bus.sram_reserved_sa = (owner_reg == SA);
  assign bus.xbar_owner       = owner_reg;
  assign bus.starve_promote   = promote;
  assign bus.resp_valid       = {tail.valid && (tail.owner == VC),
                                 tail.valid && (tail.owner == SA)};
  assign bus.resp_owner       = tail.owner;

endmodule

// File: tb/tb_spad_sram_arbiter.sv
// Directed bench for spad_sram_arbiter: cycle-by-cycle grant, promotion,
// burst and read-return checks against hand-derived sequences.
module tb_spad_sram_arbiter;
  import spad_types_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  owner_t starve_seq [10];

  spad_sram_arbiter_if bus();

  spad_sram_arbiter #(
    .SRAM_LAT   (2),
    .STARVE_MAX (8),
    .BURST_MAX  (32)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_owner(input string tag, input owner_t exp);
    logic [2:0] exp_res;
    exp_res = {exp == BE, exp == VC, exp == SA};
    check({tag, " owner"}, 32'(bus.xbar_owner), 32'(exp));
    check({tag, " reserved"},
          32'({bus.sram_reserved_be, bus.sram_reserved_vc, bus.sram_reserved_sa}),
          32'(exp_res));
  endtask

  task automatic check_resp(input string tag, input logic [1:0] exp_v, input owner_t exp_o);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'(exp_v));
    check({tag, " resp_owner"}, 32'(bus.resp_owner), 32'(exp_o));
  endtask

  initial begin
    starve_seq = '{BE, VC, BE, VC, BE, VC, BE, VC, SA, BE};
    bus.sram_req_be = 1'b0;
    bus.sram_req_vc = 1'b0;
    bus.sram_req_sa = 1'b0;
    bus.be_lock     = 1'b0;
    bus.vc_write    = 1'b0;
    bus.sa_write    = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check_owner("reset", NONE);
    check_resp("reset", 2'b00, NONE);
    check("reset promote", 32'(bus.starve_promote), 32'd0);
    nRST = 1'b1;
    tick();
    check_owner("idle", NONE);

    // VC read alone: granted one cycle later, data two cycles after grant
    bus.sram_req_vc = 1'b1;
    tick();
    check_owner("vc_rd t1", VC);
    bus.sram_req_vc = 1'b0;
    tick();
    check_owner("vc_rd t1+1", NONE);
    check_resp("vc_rd t1+1", 2'b00, NONE);
    tick();
    check_resp("vc_rd t1+2", 2'b10, VC);
    tick();
    check_resp("vc_rd t1+3", 2'b00, NONE);

    // Single requester held: owns every other cycle
    bus.sram_req_sa = 1'b1;
    bus.sa_write    = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check_owner($sformatf("single c%0d", c), (c % 2 == 1) ? SA : NONE);
      check($sformatf("single c%0d resp_valid", c), 32'(bus.resp_valid), 32'd0);
    end
    bus.sram_req_sa = 1'b0;
    tick();
    check_owner("single drop", NONE);
    tick();

    // SA write then VC read back-to-back: only the VC bit returns
    bus.sram_req_vc = 1'b1;
    bus.vc_write    = 1'b0;
    bus.sram_req_sa = 1'b1;
    bus.sa_write    = 1'b1;
    tick();
    check_owner("mix c1", VC);
    bus.sram_req_vc = 1'b0;
    tick();
    check_owner("mix c2", SA);
    check_resp("mix c2", 2'b00, NONE);
    bus.sram_req_sa = 1'b0;
    tick();
    check_owner("mix c3", NONE);
    check_resp("mix c3", 2'b10, VC);
    tick();
    check_resp("mix c4", 2'b00, NONE);

    // All three held, no lock: BE/VC alternate until SA is promoted
    bus.sram_req_be = 1'b1;
    bus.sram_req_vc = 1'b1;
    bus.sram_req_sa = 1'b1;
    bus.vc_write    = 1'b1;
    bus.sa_write    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_owner($sformatf("starve c%0d", c), starve_seq[c-1]);
      check($sformatf("starve c%0d promote", c), 32'(bus.starve_promote),
            (c == 8 || c == 9) ? 32'd1 : 32'd0);
    end
    bus.sram_req_be = 1'b0;
    bus.sram_req_vc = 1'b0;
    bus.sram_req_sa = 1'b0;
    tick();
    check_owner("starve drop", NONE);

    // Locked BE burst for 40 cycles: 32 beats, one gap, then a new burst
    bus.sram_req_be = 1'b1;
    bus.be_lock     = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_owner($sformatf("burst c%0d", c), (c == 33) ? NONE : BE);
    end
    bus.sram_req_be = 1'b0;
    bus.be_lock     = 1'b0;
    tick();
    check_owner("burst drop", NONE);
    check_resp("burst drop", 2'b00, NONE);
    tick();

    // Reset one cycle after a VC read grant, with an SA read owning the SRAM
    bus.sram_req_vc = 1'b1;
    bus.vc_write    = 1'b0;
    bus.sram_req_sa = 1'b1;
    bus.sa_write    = 1'b0;
    tick();
    check_owner("rst vc grant", VC);
    bus.sram_req_vc = 1'b0;
    tick();
    check_owner("rst sa grant", SA);
    bus.sram_req_sa = 1'b0;
    nRST = 1'b0;
    #1;
    check_owner("rst async", NONE);
    check_resp("rst async", 2'b00, NONE);
    check("rst async promote", 32'(bus.starve_promote), 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_owner($sformatf("post-rst c%0d", c), NONE);
      check_resp($sformatf("post-rst c%0d", c), 2'b00, NONE);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
